// File: rtl/generic_bus_resp_pkg.sv
// Shared definitions for the generic_bus memory responder.
//   state_e          : responder FSM states
//   CNT_W            : width of the wait-state counter (LATENCY 0..15)
//   DEFAULT_BAD_DATA : read data returned on an illegal / out-of-range access
package generic_bus_resp_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int CNT_W = 4;

  localparam logic [31:0] DEFAULT_BAD_DATA = 32'hBAD1_BAD1;

  // Saturating conversion of the LATENCY parameter to a counter load value.
  function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
    logic [CNT_W-1:0] v;
    if (lat > 15) begin
      v = 4'd15;
    end else if (lat < 0) begin
      v = 4'd0;
    end else begin
      v = CNT_W'(lat);
    end
    return v;
  endfunction

endpackage

// File: rtl/responder_mem_array.sv
// Single-port word array for the bus responder.
//   i_clk, i_rst_n : clock, async active-low reset (read register only)
//   i_idx          : word index shared by read and write
//   i_wr_en/i_be/i_wdata : byte-lane masked write, committed on the clock edge
//   i_rd_en        : load o_rdata from the array on the clock edge
//   i_rd_bad       : load o_rdata with BAD_DATA instead (error response)
//   o_rdata        : registered read data, holds until the next load
// The array itself is deliberately not reset.
module responder_mem_array
  import generic_bus_resp_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [DATA_WIDTH-1:0] BAD_DATA    = DATA_WIDTH'(DEFAULT_BAD_DATA)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic                           i_wr_en,
  input  logic [DATA_WIDTH/8-1:0]        i_be,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic                           i_rd_en,
  input  logic                           i_rd_bad,
  output logic [DATA_WIDTH-1:0]          o_rdata
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-lane masked array write.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  // Registered read port; an error response overrides the array data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= {DATA_WIDTH{1'b0}};
    end else if (i_rd_bad) begin
      r_rdata <= BAD_DATA;
    end else if (i_rd_en) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/generic_bus_mem_responder.sv
// Responder end of generic_bus_if: word-organised memory with a fixed
// number of wait states between request acceptance and response.
//   CLK, nRST   : clock, asynchronous active-low reset
//   addr        : byte address (low bits below word size are ignored)
//   wdata       : write data, byte_en : write lane enables
//   ren, wen    : read / write request (both high = illegal access)
//   busy        : low for exactly one cycle when a response completes
//   rdata       : registered read data, held between read responses
//   error       : high with busy=0 for an illegal or out-of-range access
// Request accepted on edge A: busy is low during the cycle starting at edge
// A+LATENCY. Dropping both ren and wen while waiting aborts the request.
module generic_bus_mem_responder
  import generic_bus_resp_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = {ADDR_WIDTH{1'b0}},
  parameter int                    LATENCY     = 2,
  parameter logic [DATA_WIDTH-1:0] BAD_DATA    = DATA_WIDTH'(DEFAULT_BAD_DATA)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    ren,
  input  logic                    wen,
  output logic                    busy,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    error
);

  localparam int                    BE_W    = DATA_WIDTH / 8;
  localparam int                    SHIFT   = $clog2(BE_W);
  localparam int                    IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]      LAT_CNT = lat_to_cnt(LATENCY);

  state_e r_state;
  state_e w_next;

  logic [CNT_W-1:0] r_cnt;
  logic             r_is_wr;
  logic             r_err;
  logic [IDX_W-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [BE_W-1:0]  r_be;
  logic             r_busy;
  logic             r_error;

  logic                  w_below_base;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_out_of_range;
  logic                  w_illegal;
  logic                  w_req;
  logic                  w_live_err;

  logic             w_capture;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_rd_en;
  logic             w_rd_bad;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  // Range check on the live address. The base compare runs first so the
  // subtraction never wraps for addresses below BASE_ADDR.
  assign w_below_base   = (addr < BASE_ADDR);
  assign w_offset       = w_below_base ? {ADDR_WIDTH{1'b0}} : (addr - BASE_ADDR);
  assign w_word         = w_offset >> SHIFT;
  assign w_out_of_range = w_below_base | (w_word >= DEPTH_A);
  assign w_illegal      = ren & wen;
  assign w_req          = ren | wen;
  assign w_live_err     = w_illegal | w_out_of_range;

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and datapath controls. The array read is launched on the
  // edge that enters RESP so its registered output is valid while busy=0;
  // the write commits on the edge that leaves RESP.
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_rd_en    = 1'b0;
    w_rd_bad   = 1'b0;
    w_wr_en    = 1'b0;
    w_idx      = r_idx;
    case (r_state)
      S_IDLE: begin
        w_idx = w_word[IDX_W-1:0];
        if (w_req) begin
          w_capture = 1'b1;
          if (LAT_CNT == 4'd0) begin
            w_next   = S_RESP;
            w_rd_bad = w_live_err;
            w_rd_en  = ~w_live_err & ren;
          end else begin
            w_next     = S_WAIT;
            w_cnt_load = 1'b1;
          end
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          // requester withdrew: abandon silently, nothing is written
          w_next = S_IDLE;
        end else if (r_cnt == 4'd1) begin
          w_next   = S_RESP;
          w_rd_bad = r_err;
          w_rd_en  = ~r_err & ~r_is_wr;
        end else begin
          w_next    = S_WAIT;
          w_cnt_dec = 1'b1;
        end
      end
      S_RESP: begin
        w_next  = S_IDLE;
        w_wr_en = r_is_wr & ~r_err;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request capture and wait counter.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt   <= 4'd0;
      r_is_wr <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= {IDX_W{1'b0}};
      r_wdata <= {DATA_WIDTH{1'b0}};
      r_be    <= {BE_W{1'b0}};
    end else begin
      if (w_capture) begin
        r_is_wr <= wen;
        r_err   <= w_live_err;
        r_idx   <= w_word[IDX_W-1:0];
        r_wdata <= wdata;
        r_be    <= byte_en;
      end
      if (w_cnt_load) begin
        r_cnt <= LAT_CNT;
      end else if (w_cnt_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Registered handshake outputs, derived from the state being entered.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_busy  <= 1'b1;
      r_error <= 1'b0;
    end else begin
      r_busy  <= (w_next != S_RESP);
      r_error <= w_rd_bad;
    end
  end

  responder_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS),
    .BAD_DATA   (BAD_DATA)
  ) u_mem (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_idx   (w_idx),
    .i_wr_en (w_wr_en),
    .i_be    (r_be),
    .i_wdata (r_wdata),
    .i_rd_en (w_rd_en),
    .i_rd_bad(w_rd_bad),
    .o_rdata (w_mem_rdata)
  );

  assign busy  = r_busy;
  assign error = r_error;
  assign rdata = w_mem_rdata;

endmodule

// File: tb/tb_generic_bus_mem_responder.sv
// Scoreboard bench for generic_bus_mem_responder. Four instances:
//   0: LATENCY=2, 1: LATENCY=0, 2: LATENCY=4 (all BASE 0),
//   3: LATENCY=1 with BASE 0x1000 (exercises addresses below base).
// Only one instance has a request in flight at a time, so a single queue of
// expected responses (tagged with the instance number) is used.
`timescale 1ns/1ps
module tb_generic_bus_mem_responder;

  localparam int          DEPTH     = 64;
  localparam int          LAT_P [4] = '{2, 0, 4, 1};
  localparam logic [31:0] BASE_P[4] = '{32'h0, 32'h0, 32'h0, 32'h1000};
  localparam logic [31:0] BAD       = 32'hBAD1_BAD1;

  typedef struct {
    int          d;
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] addr_a [4];
  logic [31:0] wdata_a[4];
  logic [3:0]  be_a   [4];
  logic        ren_a  [4];
  logic        wen_a  [4];
  logic        busy_a [4];
  logic [31:0] rdata_a[4];
  logic        error_a[4];

  exp_t        sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          lowcnt[4] = '{0, 0, 0, 0};
  logic [31:0] ref_mem[int];
  logic [31:0] last_rd[4];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  generic_bus_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(32'h0)) dut0 (
    .CLK(clk), .nRST(nrst), .addr(addr_a[0]), .wdata(wdata_a[0]), .byte_en(be_a[0]),
    .ren(ren_a[0]), .wen(wen_a[0]), .busy(busy_a[0]), .rdata(rdata_a[0]), .error(error_a[0]));
  generic_bus_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .BASE_ADDR(32'h0)) dut1 (
    .CLK(clk), .nRST(nrst), .addr(addr_a[1]), .wdata(wdata_a[1]), .byte_en(be_a[1]),
    .ren(ren_a[1]), .wen(wen_a[1]), .busy(busy_a[1]), .rdata(rdata_a[1]), .error(error_a[1]));
  generic_bus_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .BASE_ADDR(32'h0)) dut2 (
    .CLK(clk), .nRST(nrst), .addr(addr_a[2]), .wdata(wdata_a[2]), .byte_en(be_a[2]),
    .ren(ren_a[2]), .wen(wen_a[2]), .busy(busy_a[2]), .rdata(rdata_a[2]), .error(error_a[2]));
  generic_bus_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(32'h1000)) dut3 (
    .CLK(clk), .nRST(nrst), .addr(addr_a[3]), .wdata(wdata_a[3]), .byte_en(be_a[3]),
    .ren(ren_a[3]), .wen(wen_a[3]), .busy(busy_a[3]), .rdata(rdata_a[3]), .error(error_a[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: decide the response from the access rules and
  // update the reference memory.
  task automatic model(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output logic err);
    int          key;
    logic [31:0] m;
    err = (r && w) || (a < BASE_P[d]) || (((a - BASE_P[d]) / 4) >= DEPTH);
    if (err) begin
      rd = BAD;
      last_rd[d] = BAD;
    end else begin
      key = d * DEPTH + int'((a - BASE_P[d]) / 4);
      if (r) begin
        rd = ref_mem[key];
        last_rd[d] = rd;
      end else begin
        m = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (be[b]) m[8*b +: 8] = wd[8*b +: 8];
        end
        ref_mem[key] = m;
        rd = last_rd[d];
      end
    end
  endtask

  // Present a request (caller is at posedge+1 with the instance idle), record
  // the expected response, then wait for it and return just after the edge
  // that ends the response cycle.
  task automatic issue(input int d, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    bit   got;
    ren_a[d] = r; wen_a[d] = w; addr_a[d] = a; wdata_a[d] = wd; be_a[d] = be;
    e.d   = d;
    e.cyc = cyc + 1 + LAT_P[d];
    model(d, r, w, a, wd, be, e.rdata, e.err);
    sb.push_back(e);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (busy_a[d] === 1'b0) got = 1'b1;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL timeout dut%0d: no response within 40 cycles for addr %h", d, a);
      if (sb.size() > 0) sb.delete(sb.size() - 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int d, input int n);
    ren_a[d] = 1'b0; wen_a[d] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every busy=0 cycle is a response and is matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (nrst === 1'b1 && busy_a[d] === 1'b0) begin
        lowcnt[d] <= lowcnt[d] + 1;
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL spurious_resp dut%0d: busy=0 at cycle %0d with nothing outstanding", d, cyc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("resp_dut dut%0d", d), d, e.d);
          chk($sformatf("resp_cycle dut%0d", d), cyc, e.cyc);
          chk($sformatf("rdata dut%0d", d), rdata_a[d], e.rdata);
          chk($sformatf("error dut%0d", d), {31'd0, error_a[d]}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    logic        r, w;
    int          k;
    for (int d = 0; d < 4; d++) begin
      addr_a[d] = 32'h0; wdata_a[d] = 32'h0; be_a[d] = 4'h0;
      ren_a[d] = 1'b0; wen_a[d] = 1'b0; last_rd[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_busy dut%0d", d), {31'd0, busy_a[d]}, 32'd1);
      chk($sformatf("reset_rdata dut%0d", d), rdata_a[d], 32'h0);
      chk($sformatf("reset_error dut%0d", d), {31'd0, error_a[d]}, 32'd0);
    end
    nrst = 1'b1;
    @(posedge clk); #1;

    // Fill every word so later reads have a known reference value.
    for (int d = 0; d < 4; d++) begin
      for (int i = 0; i < DEPTH; i++) issue(d, 1'b0, 1'b1, BASE_P[d] + 32'(4 * i), $urandom, 4'hF);
      idle(d, 1);
    end

    // Full write then read, and a partial-lane merge.
    issue(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    idle(0, 1);
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("full_write_readback", rdata_a[0], 32'hDEADBEEF);
    issue(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101);
    issue(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("partial_write_merge", rdata_a[0], 32'hDE22BE44);
    idle(0, 2);

    // Zero latency, ren held high across two reads.
    issue(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    issue(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    idle(1, 2);

    // Out-of-range read, illegal access, then word 0 unchanged.
    issue(0, 1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, 4'h0);
    chk("oor_rdata", rdata_a[0], BAD);
    issue(0, 1'b1, 1'b1, 32'h0, 32'h55555555, 4'hF);
    issue(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    idle(0, 2);

    // Below-base access on the offset instance.
    issue(3, 1'b0, 1'b1, 32'h0FFC, 32'h12345678, 4'hF);
    issue(3, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0);
    idle(3, 2);

    // Abort: write to 0x20 withdrawn after one wait cycle.
    issue(2, 1'b0, 1'b1, 32'h20, 32'hCAFE0020, 4'hF);
    idle(2, 1);
    k = lowcnt[2];
    addr_a[2] = 32'h20; wdata_a[2] = 32'h0BAD0BAD; be_a[2] = 4'hF; wen_a[2] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    wen_a[2] = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("abort_no_resp", lowcnt[2], k);
    issue(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    chk("abort_word_kept", rdata_a[2], 32'hCAFE0020);
    idle(2, 1);

    // Reset during the wait phase of a write.
    addr_a[2] = 32'h20; wdata_a[2] = 32'h0BAD0BAD; be_a[2] = 4'hF; wen_a[2] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    nrst = 1'b0;
    #1;
    chk("midreset_busy", {31'd0, busy_a[2]}, 32'd1);
    chk("midreset_rdata", rdata_a[2], 32'h0);
    wen_a[2] = 1'b0;
    for (int d = 0; d < 4; d++) last_rd[d] = 32'h0;
    @(posedge clk); #2;
    nrst = 1'b1;
    @(posedge clk); #1;
    issue(2, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    chk("reset_word_kept", rdata_a[2], 32'hCAFE0020);
    idle(2, 1);

    // Random traffic on the latency-2, latency-0 and offset-base instances.
    foreach (LAT_P[d]) begin
      if (d != 2) begin
        for (int i = 0; i < 80; i++) begin
          k  = $urandom_range(0, 9);
          r  = (k < 4) || (k == 8) || (k == 9 && $urandom_range(0, 1) == 0);
          w  = (k >= 4 && k < 8) || (k == 8) || (k == 9 && !r);
          be = 4'($urandom_range(0, 15));
          if (k == 9) begin
            if (d == 3 && $urandom_range(0, 1) == 0) a = $urandom_range(0, 32'h0FFF);
            else a = BASE_P[d] + 32'(4 * DEPTH) + $urandom_range(0, 32'h00FF_FFFF);
          end else begin
            a = BASE_P[d] + 32'(4 * $urandom_range(0, DEPTH - 1)) + $urandom_range(0, 3);
          end
          issue(d, r, w, a, $urandom, be);
          if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 2));
        end
        idle(d, 2);
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
